// File: rtl/nios2_jtag_scan_pkg.sv
// Shared constants and state type for the Nios II JTAG scan master.
package nios2_jtag_scan_pkg;

    localparam int SCAN_MAX_LEN = 38;
    localparam int TLR_LEN      = 5;
    localparam int WALK_DR_LEN  = 3;
    localparam int WALK_IR_LEN  = 4;
    localparam int WALK_OUT_LEN = 2;
    localparam int RTI_PAD_LEN  = 4;

    typedef enum logic [2:0] {
        TLR_SEQ,
        IDLE,
        WALK_IN,
        SHIFT,
        WALK_OUT,
        RTI_PAD,
        RSP
    } scan_state_e;

endpackage

// File: rtl/nios2_jtag_tck_gen.sv
// TCK divider: half-period of CLK_DIV clk cycles, held low/cleared when idle.
module nios2_jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          at_top;

    assign at_top = en && (div_cnt == CW'(CLK_DIV - 1));
    assign rise   = at_top && !tck;
    assign fall   = at_top && tck;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (at_top) begin
            div_cnt <= '0;
            tck     <= !tck;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/nios2_jtag_scan_master.sv
// JTAG scan initiator: TAP reset, IR/DR scans up to MAX_LEN bits LSB-first.
// Define JTAG_SCAN_RTI_PAD_EN to add 4 Run-Test/Idle TCKs after each scan.
module nios2_jtag_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 38,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

    import nios2_jtag_scan_pkg::*;

    scan_state_e        state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   clamp_len, walk_last;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_q, rsp_d;
    logic               ir_q, ir_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               tck_en, tck_rise, tck_fall;

    nios2_jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (tck_en),
        .tck    (tck),
        .rise   (tck_rise),
        .fall   (tck_fall)
    );

    assign clamp_len = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign walk_last = ir_q ? LEN_W'(WALK_IR_LEN - 1) : LEN_W'(WALK_DR_LEN - 1);

    assign tck_en    = !(state_q inside {IDLE, RSP});
    assign busy      = tck_en;
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = rsp_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= TLR_SEQ;
            cnt_q   <= '0;
            len_q   <= '0;
            ir_q    <= 1'b0;
            data_q  <= '0;
            rsp_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    // tms/tdi are set on each falling strobe for the TCK that follows
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ir_d    = ir_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        unique case (state_q)
            TLR_SEQ: begin
                if (tck_fall) begin
                    if (cnt_q == LEN_W'(TLR_LEN)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        tms_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                        tms_d = (cnt_q < LEN_W'(TLR_LEN - 1));
                    end
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    rsp_d  = '0;
                    ir_d   = cmd_ir;
                    len_d  = clamp_len;
                    data_d = cmd_data;
                    cnt_d  = '0;
                    if (clamp_len == '0) begin
                        state_d = RSP;
                    end else begin
                        state_d = WALK_IN;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end
                end
            end
            WALK_IN: begin
                if (tck_fall) begin
                    if (cnt_q == walk_last) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = data_q[0];
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                        tms_d = (cnt_q + LEN_W'(2) < walk_last);
                    end
                end
            end
            SHIFT: begin
                if (tck_rise) begin
                    rsp_d[cnt_q] = tdo;
                end
                if (tck_fall) begin
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = WALK_OUT;
                        cnt_d   = '0;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        data_d = data_q >> 1;
                        tdi_d  = data_q[1];
                        tms_d  = (cnt_q + LEN_W'(2) == len_q);
                    end
                end
            end
            WALK_OUT: begin
                if (tck_fall) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    tms_d = 1'b0;
                    if (cnt_q == LEN_W'(WALK_OUT_LEN - 1)) begin
                        cnt_d   = '0;
`ifdef JTAG_SCAN_RTI_PAD_EN
                        state_d = RTI_PAD;
`else
                        state_d = RSP;
`endif
                    end
                end
            end
            RTI_PAD: begin
                if (tck_fall) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    tms_d = 1'b0;
                    if (cnt_q == LEN_W'(RTI_PAD_LEN - 1)) begin
                        state_d = RSP;
                        cnt_d   = '0;
                    end
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = TLR_SEQ;
            end
        endcase
    end

endmodule

// File: tb/tb_nios2_jtag_scan_master.sv
// Bench for nios2_jtag_scan_master: TAP state model on the JTAG pins,
// per-cycle output checks and directed scans with literal expectations.
module tb_nios2_jtag_scan_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 38;
    localparam int LEN_W   = 6;
    localparam int TCKP    = 2 * CLK_DIV;
`ifdef JTAG_SCAN_RTI_PAD_EN
    localparam int PAD = 4;
`else
    localparam int PAD = 0;
`endif
    localparam logic [MAX_LEN-1:0] IR_CAPTURE = 38'h1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ir = 1'b0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_ready = 1'b0;
    logic               cmd_ready, rsp_valid, tck, tms, tdi, tdo, busy;
    logic [MAX_LEN-1:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nios2_jtag_scan_master #(
        .CLK_DIV(CLK_DIV),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ir   (cmd_ir),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .tck      (tck),
        .tms      (tms),
        .tdi      (tdi),
        .tdo      (tdo),
        .busy     (busy)
    );

    typedef enum int {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PA_DR;
            PA_DR:   return m ? EX2_DR : PA_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PA_IR;
            PA_IR:   return m ? EX2_IR : PA_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    tap_t               tap = TLR;
    logic [MAX_LEN-1:0] ir_sr = '0;
    int                 tck_cnt = 0;
    bit                 tms_q[$];
    bit                 tdi_q[$];
    bit                 tdo_q[$];
    bit                 rst_edge = 1'b0;
    bit                 pending = 1'b0;

    // DR echoes tdi; IR shifts out the captured instruction register
    assign tdo = (tap == SH_DR) ? tdi : (tap == SH_IR) ? ir_sr[0] : 1'b0;

    always @(posedge tck) begin
        tck_cnt++;
        tms_q.push_back(tms);
        tdi_q.push_back(tdi);
        if (tap == SH_DR || tap == SH_IR) tdo_q.push_back(tdo);
        if (tap == CAP_IR) ir_sr = IR_CAPTURE;
        else if (tap == SH_IR) ir_sr = {tdi, ir_sr[MAX_LEN-1:1]};
        tap = tap_next(tap, tms);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [MAX_LEN-1:0] model_rsp();
        logic [MAX_LEN-1:0] r;
        r = '0;
        foreach (tdo_q[i]) if (i < MAX_LEN) r[i] = tdo_q[i];
        return r;
    endfunction

    function automatic logic [63:0] pack_tms();
        logic [63:0] a;
        a = '0;
        foreach (tms_q[i]) if (i < 64) a[i] = tms_q[i];
        return a;
    endfunction

    task automatic clear_logs();
        tck_cnt = 0;
        tms_q.delete();
        tdi_q.delete();
        tdo_q.delete();
    endtask

    always @(posedge clk) rst_edge = !reset_n;

    always @(negedge clk) begin
        if (rst_edge) begin
            chk("reset_outputs",
                64'({tck, tms, tdi, cmd_ready, rsp_valid, busy, rsp_data}),
                64'({6'b010001, 38'h0}));
        end else if (rsp_valid) begin
            chk("rsp_expected", 64'(pending), 64'd1);
            chk("rsp_data_model", 64'(rsp_data), 64'(model_rsp()));
            chk("rsp_quiet", 64'({cmd_ready, busy, tck}), 64'd0);
        end else if (cmd_ready) begin
            chk("idle_quiet", 64'({busy, tck}), 64'd0);
        end else begin
            chk("busy_active", 64'(busy), 64'd1);
        end
    end

    task automatic tlr_check(input string nm);
        int n;
        n = 0;
        clear_logs();
        while (!cmd_ready && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({nm, "_cycles"}, 64'(n), 64'(6 * TCKP));
        chk({nm, "_tcks"}, 64'(tck_cnt), 64'd6);
        chk({nm, "_tms"}, pack_tms(), 64'h1F);
        chk({nm, "_tap_rti"}, 64'(int'(tap)), 64'(int'(RTI)));
    endtask

    task automatic do_scan(input string nm, input bit ir, input int len,
                           input logic [MAX_LEN-1:0] data,
                           input logic [MAX_LEN-1:0] exp_lit,
                           input int hold);
        int eff, wl, n, ntck, k;
        logic [63:0] e, a;
        eff = (len > MAX_LEN) ? MAX_LEN : len;
        wl = ir ? 4 : 3;
        ntck = (eff == 0) ? 0 : eff + wl + 2 + PAD;
        cmd_valid = 1'b1;
        cmd_ir = ir;
        cmd_len = LEN_W'(len);
        cmd_data = data;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_accept"}, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        clear_logs();
        pending = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 5000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, 64'(n), 64'(ntck * TCKP));
        chk({nm, "_tcks"}, 64'(tck_cnt), 64'(ntck));
        e = '0;
        k = 0;
        if (eff > 0) begin
            for (int i = 0; i < wl; i++) begin
                e[k] = (i < wl - 2);
                k++;
            end
            for (int i = 0; i < eff; i++) begin
                e[k] = (i == eff - 1);
                k++;
            end
            e[k] = 1'b1;
        end
        chk({nm, "_tms"}, pack_tms(), e);
        a = '0;
        e = '0;
        for (int i = 0; i < eff; i++) begin
            e[i] = data[i];
            if (wl + i < tdi_q.size()) a[i] = tdi_q[wl + i];
        end
        chk({nm, "_tdi"}, a, e);
        chk({nm, "_rsp"}, 64'(rsp_data), 64'(exp_lit));
        chk({nm, "_tap_rti"}, 64'(int'(tap)), 64'(int'(RTI)));
        if (hold > 0) cmd_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        pending = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({nm, "_ready_after"}, 64'({cmd_ready, rsp_valid}), 64'b10);
    endtask

    task automatic abort_scan();
        int n;
        cmd_valid = 1'b1;
        cmd_ir = 1'b0;
        cmd_len = LEN_W'(38);
        cmd_data = 38'h3F_FFFF_FFFF;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        clear_logs();
        pending = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (tck_cnt < 14 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit10", 64'(tck_cnt), 64'd14);
        pending = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tlr_check("tlr_rerun");
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tlr_check("tlr");
        do_scan("dr38", 1'b0, 38, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 0);
        do_scan("ir2", 1'b1, 2, 38'h2, 38'h1, 0);
        do_scan("dr8_hold", 1'b0, 8, 38'hC3, 38'hC3, 50);
        do_scan("len0", 1'b0, 0, 38'h3F, 38'h0, 0);
        do_scan("len50", 1'b0, 50, 38'h12_3456_7890, 38'h12_3456_7890, 0);
        do_scan("dr4", 1'b0, 4, 38'h9, 38'h9, 3);
        abort_scan();
        do_scan("dr38_post", 1'b0, 38, 38'h15_0F0F_0F0F, 38'h15_0F0F_0F0F, 0);
        do_scan("ir5", 1'b1, 5, 38'h1B, 38'h1, 0);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
